fetch_pc_unit: RTL and testbench

//  Program-counter stage of the single-cycle MIPS core; sits directly upstream of the instruction memory.

---
 rtl/mips_pkg.sv | 12 +
 rtl/pc_next.sv | 23 ++
 rtl/fetch_pc_unit.sv | 63 ++++++
 tb/tb_fetch_pc_unit.sv | 130 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcode constants and fetch-stage state shared by the fetch and control units
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT, ST_FAULT} fetch_state_e;
endpackage

// File: rtl/pc_next.sv
// pc_next: combinational next-PC selection between sequential, taken beq and j
module pc_next
  import mips_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] instruction_i,
  input  logic        alu_zero_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] next_pc_o,
  output logic        is_j_o
);
  logic [5:0]  op;
  logic        is_beq;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  assign op         = instruction_i[31:26];
  assign is_beq     = op == OP_BEQ;
  assign is_j_o     = op == OP_J;
  assign pc_plus4_o = pc_i + 32'd4;
  assign br_tgt     = pc_plus4_o + {{14{instruction_i[15]}}, instruction_i[15:0], 2'b00};
  assign j_tgt      = {pc_plus4_o[31:28], instruction_i[25:0], 2'b00};
  assign next_pc_o  = is_j_o ? j_tgt : (is_beq && alu_zero_i) ? br_tgt : pc_plus4_o;
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC register with boot/run/halt/fault control and a retired-instruction counter
module fetch_pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IM_WORDS  = 100,
  parameter bit          HALT_SELF = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        alu_zero,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired_count
);
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, cnt_q, cnt_d, next_pc;
  logic         is_j, oob, self_j;
  pc_next u_pc_next (
    .pc_i          (pc_q),
    .instruction_i (instruction),
    .alu_zero_i    (alu_zero),
    .pc_plus4_o    (pc_plus4),
    .next_pc_o     (next_pc),
    .is_j_o        (is_j)
  );
  assign oob    = (next_pc >> 2) >= 32'(IM_WORDS);
  assign self_j = HALT_SELF && is_j && (next_pc == pc_q);
  // Out-of-range wins over self-jump; a fault never counts as retired.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (state_q == ST_BOOT) state_d = ST_RUN;
    else if (state_q == ST_RUN && !stall) begin
      if (oob) state_d = ST_FAULT;
      else begin
        cnt_d   = cnt_q + 32'd1;
        state_d = self_j ? ST_HALT : ST_RUN;
        pc_d    = self_j ? pc_q : next_pc;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end
  assign pc            = pc_q;
  assign retired_count = cnt_q;
  assign halted        = state_q == ST_HALT;
  assign fault         = state_q == ST_FAULT;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: table-driven vectors plus hand sequences, checked through an expected-result queue
module tb_fetch_pc_unit;
  logic        clk, reset, alu_zero, stall, halted, fault;
  logic [31:0] instruction, pc, pc_plus4, retired_count;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        h;
    logic        f;
  } exp_t;
  typedef struct {
    logic [31:0] ins;
    logic        az;
    logic        st;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        h;
    logic        f;
  } vec_t;
  exp_t sb[$];
  vec_t tbl[13];
  int total = 0;
  int bad = 0;
  localparam logic [31:0] ADDI = 32'h2008_0020;
  fetch_pc_unit dut (
    .clk           (clk),
    .reset         (reset),
    .instruction   (instruction),
    .alu_zero      (alu_zero),
    .stall         (stall),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .halted        (halted),
    .fault         (fault),
    .retired_count (retired_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask
  task automatic check_now(input string nm, input logic [31:0] epc, input logic [31:0] ecnt,
                           input logic eh, input logic ef);
    chk({nm, ".pc"}, pc, epc);
    chk({nm, ".pc_plus4"}, pc_plus4, epc + 32'd4);
    chk({nm, ".count"}, retired_count, ecnt);
    chk({nm, ".halted"}, 32'(halted), 32'(eh));
    chk({nm, ".fault"}, 32'(fault), 32'(ef));
  endtask
  task automatic step(input logic [31:0] ins, input logic az, input logic st,
                      input logic [31:0] epc, input logic [31:0] ecnt,
                      input logic eh, input logic ef, input string nm);
    exp_t e;
    e.pc = epc; e.cnt = ecnt; e.h = eh; e.f = ef;
    instruction = ins;
    alu_zero    = az;
    stall       = st;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      check_now(nm, e.pc, e.cnt, e.h, e.f);
    end
  endtask
  task automatic do_reset(input string nm);
    reset = 1'b1;
    #1;
    check_now(nm, 32'h0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step(ADDI, 1'b0, 1'b0, 32'h0, 32'd0, 1'b0, 1'b0, {nm, ".boot"});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    clk = 1'b0; reset = 1'b1; instruction = ADDI; alu_zero = 1'b0; stall = 1'b0;
    tbl[0]  = '{ADDI,          1'b0, 1'b0, 32'h04, 32'd1,  1'b0, 1'b0};
    tbl[1]  = '{32'h0800_0008, 1'b0, 1'b0, 32'h20, 32'd2,  1'b0, 1'b0};
    tbl[2]  = '{32'h1232_0009, 1'b0, 1'b0, 32'h24, 32'd3,  1'b0, 1'b0};
    tbl[3]  = '{32'h0800_0008, 1'b0, 1'b0, 32'h20, 32'd4,  1'b0, 1'b0};
    tbl[4]  = '{32'h1232_0009, 1'b1, 1'b0, 32'h48, 32'd5,  1'b0, 1'b0};
    tbl[5]  = '{32'h0800_0008, 1'b0, 1'b1, 32'h48, 32'd5,  1'b0, 1'b0};
    tbl[6]  = '{32'h1000_FFFF, 1'b1, 1'b0, 32'h48, 32'd6,  1'b0, 1'b0};
    tbl[7]  = '{32'h1000_FFFF, 1'b1, 1'b0, 32'h48, 32'd7,  1'b0, 1'b0};
    tbl[8]  = '{32'h0800_0011, 1'b0, 1'b0, 32'h44, 32'd8,  1'b0, 1'b0};
    tbl[9]  = '{32'h0800_000E, 1'b0, 1'b0, 32'h38, 32'd9,  1'b0, 1'b0};
    tbl[10] = '{32'h1232_0009, 1'b0, 1'b1, 32'h38, 32'd9,  1'b0, 1'b0};
    tbl[11] = '{32'h0800_001F, 1'b0, 1'b0, 32'h7C, 32'd10, 1'b0, 1'b0};
    tbl[12] = '{32'h0800_001F, 1'b0, 1'b0, 32'h7C, 32'd11, 1'b1, 1'b0};
    do_reset("rst0");
    for (int i = 0; i < 13; i++)
      step(tbl[i].ins, tbl[i].az, tbl[i].st, tbl[i].pc, tbl[i].cnt, tbl[i].h, tbl[i].f,
           $sformatf("vec%0d", i));
    for (int i = 0; i < 10; i++)
      step(32'h0800_001F, 1'b0, 1'b0, 32'h7C, 32'd11, 1'b1, 1'b0, $sformatf("halt_hold%0d", i));
    do_reset("rst_from_halt");
    step(32'h0800_0063, 1'b0, 1'b0, 32'h18C, 32'd1, 1'b0, 1'b0, "j_word99");
    step(32'h0800_0064, 1'b0, 1'b0, 32'h18C, 32'd1, 1'b0, 1'b1, "j_word100_fault");
    for (int i = 0; i < 3; i++)
      step(ADDI, 1'b0, 1'b0, 32'h18C, 32'd1, 1'b0, 1'b1, $sformatf("fault_hold%0d", i));
    do_reset("rst_from_fault");
    step(32'h1000_FFFE, 1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 1'b1, "beq_wrap_fault");
    do_reset("rst_stall");
    step(32'h0800_000E, 1'b0, 1'b0, 32'h38, 32'd1, 1'b0, 1'b0, "j_0e");
    for (int i = 0; i < 3; i++)
      step(ADDI, 1'b0, 1'b1, 32'h38, 32'd1, 1'b0, 1'b0, $sformatf("stall%0d", i));
    step(ADDI, 1'b0, 1'b0, 32'h3C, 32'd2, 1'b0, 1'b0, "after_stall");
    #2;
    reset = 1'b1;
    #1;
    check_now("async_reset", 32'h0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step(ADDI, 1'b0, 1'b0, 32'h0, 32'd0, 1'b0, 1'b0, "async.boot");
    step(ADDI, 1'b0, 1'b0, 32'h4, 32'd1, 1'b0, 1'b0, "async.run");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
